fft_ctrl: RTL
=============

# fft_ctrl

Sequencing controller for the in-place radix-2 decimation-in-time FFT datapath. It generates bit-reversed load addresses, per-stage butterfly read/write addresses and twiddle indices, and natural-order unload addresses. It drives the sample RAM, the twiddle ROM and the butterfly unit, and exposes a start/ready handshake to the testbench or host.

## Interface

Parameters:
- LOG2N, 4: log2 of FFT length; N = 2^LOG2N, 2 ≤ LOG2N ≤ 15.
- BF_LAT, 2: butterfly pipeline latency in cycles, from read-address issue to write-back; ≥ 1.

Ports:
- sys_clk  in  1  system clock; all state changes on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- write  in  1  sample-write strobe; sampled only in LOAD.
- ready  out  1  high in IDLE only.
- load_we  out  1  RAM write enable for the incoming sample (combinational: write & LOAD).
- load_addr  out  LOG2N  bit-reversed load address.
- bf_valid  out  1  butterfly operand read issued this cycle.
- rd_addr_a / rd_addr_b  out  LOG2N  butterfly operand addresses.
- tw_addr  out  LOG2N-1  twiddle ROM index.
- en_a / en_b  out  1  write-back enables for butterfly results; identical to each other.
- wb_addr_a / wb_addr_b  out  LOG2N  write-back addresses.
- stage  out  4  current stage index, 0 outside COMPUTE.
- out_addr  out  LOG2N  unload read address.
- out_valid  out  1  RAM read data for out_idx is valid.
- out_idx  out  LOG2N  output bin index aligned with out_valid.
- done  out  1  one-cycle pulse at transform completion.

## Operation

The state machine has five states: IDLE, LOAD, COMPUTE, STALL and UNLOAD.

- IDLE: ready=1.
  - start=1 → LOAD next cycle; load counter cleared.
  - write in the same cycle as start is ignored.
- LOAD:
  - Each cycle with write=1: load_we=1 and load_addr=bitrev(cnt), then cnt++.
  - write=0 cycles stall without penalty.
  - After the N-th write → COMPUTE; stage=0, j=0.
- COMPUTE: one butterfly per cycle, j = 0..N/2-1, s = stage.
  - half = 2^s, pos = j mod half, grp = j >> s.
  - rd_addr_a = grp·2·half + pos; rd_addr_b = rd_addr_a + half.
  - tw_addr = pos << (LOG2N-1-s).
  - bf_valid = 1.
  - At j = N/2-1 → STALL.
- STALL: bf_valid=0 for exactly BF_LAT cycles, so the stage's write-backs complete before the next stage reads.
  - Then, if s < LOG2N-1: stage++, j=0 → COMPUTE.
  - Otherwise → UNLOAD with cnt=0.
- Write-back: en_a/en_b and wb_addr_a/b are rd_addr_a/b and bf_valid delayed by exactly BF_LAT registers. The delay line runs in every state.
- UNLOAD:
  - out_addr = cnt, cnt = 0..N-1, one per cycle.
  - out_valid and out_idx are out_addr and an internal "unload read issued" flag delayed by 1 cycle (synchronous RAM).
  - After cnt = N-1 → IDLE.
  - done pulses in the cycle the last out_valid is high.
- Outside the owning state:
  - start is ignored in every state except IDLE.
  - write is ignored outside LOAD (load_we=0).
- Address arithmetic is unsigned, LOG2N bits, and never overflows for valid j and s.

## Timing

- Reset (async assert): state=IDLE, ready=1; all counters, the write-back delay line, out_valid, done, bf_valid, en_a/en_b = 0; every address output = 0; stage=0.
- Reset mid-operation: the transform is abandoned immediately with no write-backs afterwards. The next start begins a fresh LOAD.
- Latencies:
  - start → LOAD: 1 cycle.
  - N-th write → first bf_valid: 1 cycle.
  - COMPUTE+STALL total: LOG2N·(N/2 + BF_LAT) cycles (40 for the defaults).
  - Last STALL cycle → first out_addr: 1 cycle.
  - out_addr → out_valid: 1 cycle.
  - Last out_valid/done → ready=1: next cycle.
- Last stage: the final write-back coincides with the last STALL cycle, so UNLOAD never reads stale data.
- bf_valid and en_a may be high in the same cycle (read of butterfly j+BF_LAT overlaps write of j). Addresses are disjoint within a stage.

## Test plan

- Reset: assert sys_rst mid-cycle, then release → ready=1 and all other outputs 0 immediately, with no clock edge needed.
- Load with gaps, defaults: start, then 16 writes with random idle cycles → load_addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. load_we=0 on idle cycles. bf_valid first asserts 1 cycle after the 16th write.
- Compute addressing:
  - Stage 0: (a,b,tw) = (0,1,0),(2,3,0)…(14,15,0).
  - Stage 3: (0,8,0),(1,9,1)…(7,15,7).
  - en_a/wb_addr equal bf_valid/rd_addr delayed exactly 2 cycles.
  - 2 bubble cycles between stages; 40 cycles total.
- Unload: out_addr 0..15 on consecutive cycles; out_valid/out_idx follow 1 cycle later; done high together with out_idx=15; ready=1 next cycle.
- Ignored inputs: start pulses during LOAD/COMPUTE/UNLOAD and write pulses during COMPUTE → no state change, load_we stays 0, address sequences unchanged.
- Reset mid-COMPUTE (stage 2, j=3) → en_a/en_b drop immediately with no later write-back. A new start plus 16 writes reproduces the correct full sequence.

Source files
------------

// File: rtl/fft_ctrl_if.sv
// Host <-> FFT controller bundle: sample load handshake, datapath addressing and unload stream.
interface fft_ctrl_if #(parameter int LOG2N = 4);
   logic             start;
   logic             write;
   logic             ready;
   logic             load_we;
   logic [LOG2N-1:0] load_addr;
   logic             bf_valid;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             en_a;
   logic             en_b;
   logic [LOG2N-1:0] wb_addr_a;
   logic [LOG2N-1:0] wb_addr_b;
   logic [3:0]       stage;
   logic [LOG2N-1:0] out_addr;
   logic             out_valid;
   logic [LOG2N-1:0] out_idx;
   logic             done;

   modport master (
      output start, write,
      input  ready, load_we, load_addr, bf_valid, rd_addr_a, rd_addr_b, tw_addr,
             en_a, en_b, wb_addr_a, wb_addr_b, stage, out_addr, out_valid, out_idx, done
   );

   modport slave (
      input  start, write,
      output ready, load_we, load_addr, bf_valid, rd_addr_a, rd_addr_b, tw_addr,
             en_a, en_b, wb_addr_a, wb_addr_b, stage, out_addr, out_valid, out_idx, done
   );
endinterface

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: bit-reversed load, per-stage butterfly
// addressing with a BF_LAT write-back delay line, and natural-order unload.
module fft_ctrl #(
   parameter int LOG2N  = 4,
   parameter int BF_LAT = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   fft_ctrl_if.slave  bus
);
   localparam int         N    = 1 << LOG2N;
   localparam int         CW   = LOG2N + 1;
   localparam int         SW   = $clog2(BF_LAT + 1);
   localparam logic [3:0] LAST = 4'(LOG2N - 1);

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, STALL, UNLOAD} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [LOG2N-2:0] j_q;
   logic [3:0]       stage_q;
   logic [SW-1:0]    scnt_q;
   logic             out_valid_q, done_q;
   logic [LOG2N-1:0] out_idx_q;

   logic [BF_LAT-1:0]                 en_q;
   logic [BF_LAT-1:0][LOG2N-1:0]      wa_q, wb_q;

   logic             bf_valid, issue;
   logic [LOG2N-1:0] half, pos, addr_a, addr_b, lrev, out_addr;
   logic [LOG2N-2:0] tw;

   always_comb begin
      half   = LOG2N'(1) << stage_q;
      pos    = LOG2N'(j_q) & (half - LOG2N'(1));
      addr_a = ((LOG2N'(j_q) >> stage_q) << (stage_q + 4'd1)) | pos;
      addr_b = addr_a | half;
      tw     = (LOG2N-1)'(pos << (LAST - stage_q));
      for (int k = 0; k < LOG2N; k++) lrev[k] = cnt_q[LOG2N-1-k];
   end

   assign bf_valid = (state_q == COMPUTE);
   // cnt_q == N marks the drain cycle that lets the last read return before IDLE
   assign issue    = (state_q == UNLOAD) && !cnt_q[LOG2N];
   assign out_addr = issue ? cnt_q[LOG2N-1:0] : '0;

   assign bus.ready     = (state_q == IDLE);
   assign bus.load_we   = bus.write && (state_q == LOAD);
   assign bus.load_addr = lrev;
   assign bus.bf_valid  = bf_valid;
   assign bus.rd_addr_a = bf_valid ? addr_a : '0;
   assign bus.rd_addr_b = bf_valid ? addr_b : '0;
   assign bus.tw_addr   = bf_valid ? tw : '0;
   assign bus.stage     = bf_valid ? stage_q : '0;
   assign bus.en_a      = en_q[BF_LAT-1];
   assign bus.en_b      = en_q[BF_LAT-1];
   assign bus.wb_addr_a = wa_q[BF_LAT-1];
   assign bus.wb_addr_b = wb_q[BF_LAT-1];
   assign bus.out_addr  = out_addr;
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.done      = done_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         en_q <= '0;
         wa_q <= '0;
         wb_q <= '0;
      end else begin
         en_q[0] <= bf_valid;
         wa_q[0] <= bus.rd_addr_a;
         wb_q[0] <= bus.rd_addr_b;
         for (int k = 1; k < BF_LAT; k++) begin
            en_q[k] <= en_q[k-1];
            wa_q[k] <= wa_q[k-1];
            wb_q[k] <= wb_q[k-1];
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         j_q         <= '0;
         stage_q     <= '0;
         scnt_q      <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         out_valid_q <= issue;
         out_idx_q   <= out_addr;
         done_q      <= issue && (cnt_q == CW'(N - 1));
         case (state_q)
            IDLE: if (bus.start) begin
               state_q <= LOAD;
               cnt_q   <= '0;
            end
            LOAD: if (bus.write) begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_q <= COMPUTE;
                  j_q     <= '0;
                  stage_q <= '0;
               end
            end
            COMPUTE: begin
               j_q <= j_q + 1'b1;
               if (&j_q) begin
                  state_q <= STALL;
                  scnt_q  <= '0;
               end
            end
            STALL: begin
               scnt_q <= scnt_q + SW'(1);
               if (scnt_q == SW'(BF_LAT - 1)) begin
                  scnt_q <= '0;
                  j_q    <= '0;
                  if (stage_q == LAST) begin
                     state_q <= UNLOAD;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= COMPUTE;
                     stage_q <= stage_q + 4'd1;
                  end
               end
            end
            UNLOAD: begin
               if (cnt_q[LOG2N]) state_q <= IDLE;
               else              cnt_q   <= cnt_q + CW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
